uart_tx: RTL
============

# uart_tx

Transmit half of the UART block. Accepts parallel words over a valid/ready handshake and serialises each word onto `tx` in this order:

- start bit, low;
- data bits, LSB first;
- optional parity bit;
- one or two stop bits, high.

Bit timing comes from an external `baud_tick` enable at baud × OVERSAMPLE, the same tick rate the receiver uses, so both ends share one baud generator.

## Interface
- DATA_WIDTH, 8, bits per word
- PARITY, 1, 0: none; 1: even (parity bit = XOR of data); 2: odd (parity bit = XNOR of data)
- OVERSAMPLE, 16, baud_tick pulses per bit period; ≥ 2
- STOP_BITS, 1, number of stop bits; 1 or 2
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  reset, asynchronous, active-low
- baud_tick  input  1  single-clk-cycle enable pulse at baud × OVERSAMPLE
- data_in  input  DATA_WIDTH  word to send; sampled only on accept
- data_valid  input  1  word on data_in is offered
- data_ready  output  1  high only in IDLE; accept = data_valid & data_ready on a clk edge
- tx  output  1  serial line, registered, idles high
- busy  output  1  high from the cycle after accept until the frame ends
- tx_done  output  1  one-clk pulse on the cycle the FSM returns to IDLE

## Operation
- States: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
- Counters:
  - tick_cnt counts baud_ticks within a bit, 0..OVERSAMPLE-1, width $clog2(OVERSAMPLE).
  - bit_cnt counts data bits 0..DATA_WIDTH-1, and stop bits 0..STOP_BITS-1.
- IDLE:
  - tx = 1, data_ready = 1.
  - On accept: latch data_in into shift_reg, compute the parity bit from data_in, clear both counters, go to START.
- Bit advance: every state except IDLE advances on the baud_tick where tick_cnt == OVERSAMPLE-1; tick_cnt then wraps to 0.
- START: tx = 0 for OVERSAMPLE ticks.
- DATA:
  - tx = shift_reg[0].
  - On each bit advance, shift right and increment bit_cnt.
  - After bit DATA_WIDTH-1, go to PARITY, or to STOP when PARITY = 0.
- PARITY: tx = parity bit for OVERSAMPLE ticks.
- STOP:
  - tx = 1 for STOP_BITS × OVERSAMPLE ticks, then go to IDLE and pulse tx_done.
  - No new word is accepted until IDLE is reached.
- data_valid while not in IDLE is ignored; data_in need not be held after accept.
- Illegal parameters (PARITY > 2, STOP_BITS ∉ {1,2}, OVERSAMPLE < 2) cause a $fatal at elaboration.

## Timing
- Reset values: tx = 1, data_ready = 1, busy = 0, tx_done = 0. State = IDLE, counters = 0, shift_reg = 0.
- Reset asserted mid-frame: tx goes high asynchronously and the frame is abandoned, with no tx_done.
- Accept latency: tx falls on the clk edge after accept, and data_ready/busy change on the same edge.
- The first tick counted is the first baud_tick strictly after the accept edge. A baud_tick coincident with accept is not counted.
- Start-bit length is therefore between OVERSAMPLE-1 and OVERSAMPLE tick periods. This is acceptable jitter (< 1/OVERSAMPLE bit).
- Frame length is exactly (1 + DATA_WIDTH + (PARITY≠0) + STOP_BITS) × OVERSAMPLE counted ticks, measured from the first counted tick.
- tx_done and data_ready both rise on the edge after the last stop-bit tick. A new accept is legal on that same cycle.
- Back-to-back words: the idle gap between the last stop bit and the next start bit is 1 clk.
- baud_tick must be low between pulses. A tick held high for N cycles counts N times (not guarded).

## Structure
- Shared package uart_pkg:
  - parity_e (PARITY_NONE = 0, PARITY_EVEN = 1, PARITY_ODD = 2).
  - tx_state_t enum logic [2:0] {IDLE, START, DATA, PARITY, STOP}.
  - Function parity_bit(data, mode).
- Sub-modules: none inside uart_tx. The baud generator uart_baud_gen (CLOCK_FREQ, BAUD_RATE, OVERSAMPLE → baud_tick) lives beside it in the UART top and is shared with the receiver.

## Test plan
All scenarios use DATA_WIDTH = 8 and OVERSAMPLE = 16, with baud_tick every clk unless stated.

- **0x55, PARITY = 1:**
  - Required tx: 0, 1,0,1,0,1,0,1,0, parity 0, stop 1, each bit held 16 ticks.
  - Required handshake: tx_done after 176 ticks; busy high throughout; data_ready low throughout.
- **0x80, PARITY = 2:**
  - Required tx: data bits 0,0,0,0,0,0,0,1, parity 0.
  - Repeat with 0x00 → parity 1.
- **PARITY = 0, STOP_BITS = 2, 0xFF:** required frame is 0, eight 1s, then 32 ticks high; tx_done at tick 176.
- **Back-to-back and ignored valid:**
  - Send 0xA5 then 0x3C with data_valid held high.
  - Required: second start bit begins exactly 1 clk after tx_done.
  - Required: data_valid pulses mid-frame are ignored.
- **Reset mid-frame:**
  - Assert rst_n = 0 during data bit 3 of 0xC3.
  - Required: tx = 1 immediately, no tx_done, data_ready = 1 after release.
  - Required: a subsequent 0x01 frame is correct.
- **Sparse ticks (baud_tick every 5 clk):**
  - Required: each bit lasts 80 clk ±5.
  - Required: loopback into the receiver returns the same word with parity_error = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and the parity helper.
package uart_pkg;

  localparam int MAX_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity makes the total count of ones even (XOR of data); odd inverts it.
  // Narrower words are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                      input parity_e mode);
    logic p;
    p = ^data;
    case (mode)
      PARITY_EVEN: parity_bit = p;
      PARITY_ODD:  parity_bit = ~p;
      default:     parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits,
// timed by an external baud_tick running at baud x OVERSAMPLE.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 1,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  import uart_pkg::*;

  if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      OVERSAMPLE < 2 || DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_param_check
    $fatal(1, "uart_tx: illegal parameter combination");
  end

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  // The PARITY parameter shadows the package state literal, so the state is scoped explicitly.
  localparam tx_state_t AFTER_DATA = (PARITY == 0) ? STOP : uart_pkg::PARITY;

  tx_state_t             state, state_next;
  logic [TW-1:0]         tick_cnt, tick_next;
  logic [BW-1:0]         bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  par_reg, par_next;
  logic                  tx_next;
  logic                  done_next;
  logic                  bit_end;

  assign bit_end    = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));
  assign data_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // State, counters, data path and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx        <= tx_next;
      tx_done   <= done_next;
    end
  end

  // Next-state, counter and serial-line decode.
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    par_next   = par_reg;
    done_next  = 1'b0;
    tx_next    = 1'b1;

    if (state != IDLE && baud_tick) begin
      tick_next = bit_end ? '0 : tick_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (data_valid) begin
          shift_next = data_in;
          par_next   = parity_bit(MAX_DATA_WIDTH'(data_in), parity_e'(PARITY));
          tick_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            bit_next   = '0;
            state_next = AFTER_DATA;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_end) begin
          bit_next   = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is registered, so it is decoded from where the FSM will be next cycle.
    case (state_next)
      START:            tx_next = 1'b0;
      DATA:             tx_next = shift_next[0];
      uart_pkg::PARITY: tx_next = par_next;
      default:          tx_next = 1'b1;
    endcase
  end

endmodule
